// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor
//   Consumer-side accuracy monitor for registered approximate adders. Accepts
//   (in_a, in_b, in_sum) triples over a programmed window. It recomputes the
//   exact sum and accumulates error statistics: the error count, the maximum
//   error distance (ED) and the saturating cumulative ED.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, num_samples  start pulse (IDLE only) and window length
//   in_valid/in_ready   sample handshake; in_a/in_b operands, in_sum approx sum
//   busy, done          window in progress / one-cycle completion pulse
//   sample_cnt          samples processed in the current/last window
//   err_count           samples with nonzero ED
//   max_ed, sum_ed      largest ED, cumulative ED (saturating)
module approx_adder_err_monitor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] acc_cnt_d;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             start_ok;

  // Pipeline registers
  logic             s1_v_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [WIDTH:0]   s1_sum_q;
  logic             s2_v_q;
  logic [WIDTH:0]   ed_q;
  logic [WIDTH:0]   exact_d;
  logic [WIDTH:0]   ed_d;

  // Statistics
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] err_q;
  logic [WIDTH:0]   max_q;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W:0]   sum_ext_d;
  logic [ACC_W-1:0] sum_d;

  // ready_q is only ever set while in RUN, so it alone qualifies an accept
  assign accept    = in_valid && ready_q;
  assign start_ok  = start && (state_q == S_IDLE);
  assign acc_cnt_d = acc_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      acc_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            target_q  <= num_samples;
            acc_cnt_q <= '0;
            if (num_samples == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_d;
            if (acc_cnt_d == target_q) begin
              state_q <= S_DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (!s1_v_q && !s2_v_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Exact sum is WIDTH+1 bits wide, so the carry out is never lost
  always_comb begin
    exact_d = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    if (exact_d >= s1_sum_q) begin
      ed_d = exact_d - s1_sum_q;
    end else begin
      ed_d = s1_sum_q - exact_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sum_q <= '0;
      s2_v_q   <= 1'b0;
      ed_q     <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_sum_q <= in_sum;
      end
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        ed_q <= ed_d;
      end
    end
  end

  // One extra bit catches accumulator overflow; on carry the sum pins at all-ones
  always_comb begin
    sum_ext_d = {1'b0, sum_q} + (ACC_W+1)'(ed_q);
    sum_d     = sum_ext_d[ACC_W] ? '1 : sum_ext_d[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (start_ok) begin
      cnt_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else if (s2_v_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (ed_q != '0) begin
        err_q <= err_q + CNT_W'(1);
      end
      if (ed_q > max_q) begin
        max_q <= ed_q;
      end
      sum_q <= sum_d;
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = cnt_q;
  assign err_count  = err_q;
  assign max_ed     = max_q;
  assign sum_ed     = sum_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor: two instances (40-bit and 20-bit
// accumulators) share all inputs. A timing-level reference model predicts
// handshake, done/busy and statistics every cycle.
module tb_approx_adder_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] num_samples;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [16:0] in_sum;

  logic        in_ready0, busy0, done0;
  logic [31:0] sample_cnt0, err_count0;
  logic [16:0] max_ed0;
  logic [39:0] sum_ed0;

  logic        in_ready1, busy1, done1;
  logic [31:0] sample_cnt1, err_count1;
  logic [16:0] max_ed1;
  logic [19:0] sum_ed1;

  approx_adder_err_monitor #(.WIDTH(16), .CNT_W(32), .ACC_W(40)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .in_sum(in_sum), .busy(busy0), .done(done0), .sample_cnt(sample_cnt0),
    .err_count(err_count0), .max_ed(max_ed0), .sum_ed(sum_ed0)
  );

  approx_adder_err_monitor #(.WIDTH(16), .CNT_W(32), .ACC_W(20)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .in_sum(in_sum), .busy(busy1), .done(done1), .sample_cnt(sample_cnt1),
    .err_count(err_count1), .max_ed(max_ed1), .sum_ed(sum_ed1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int k    = 0;

  // Reference model
  typedef struct {
    int unsigned ed;
    int          due;
  } pend_t;

  pend_t             pq[$];
  bit                m_idle, m_busy, m_done, m_ready;
  int unsigned       remaining;
  int                done_edge;
  int unsigned       m_cnt, m_err, m_max;
  longint unsigned   m_sum40, m_sum20;
  localparam longint unsigned MAX40 = (64'd1 << 40) - 1;
  localparam longint unsigned MAX20 = (64'd1 << 20) - 1;

  function automatic void model_reset();
    pq.delete();
    m_idle = 1; m_busy = 0; m_done = 0; m_ready = 0;
    remaining = 0; done_edge = -1;
    m_cnt = 0; m_err = 0; m_max = 0; m_sum40 = 0; m_sum20 = 0;
  endfunction

  function automatic void apply(input int unsigned ed);
    m_cnt++;
    if (ed != 0) m_err++;
    if (ed > m_max) m_max = ed;
    m_sum40 = (m_sum40 + ed > MAX40) ? MAX40 : m_sum40 + ed;
    m_sum20 = (m_sum20 + ed > MAX20) ? MAX20 : m_sum20 + ed;
  endfunction

  function automatic int unsigned ed_of(input logic [15:0] a, input logic [15:0] b,
                                        input logic [16:0] s);
    int exact, sv;
    exact = int'(a) + int'(b);
    sv    = int'(s);
    return (exact >= sv) ? int'(exact - sv) : int'(sv - exact);
  endfunction

  // Called at each rising edge with the inputs that were presented to it
  function automatic void model_edge(input bit st, input int unsigned n, input bit v,
                                     input logic [15:0] a, input logic [15:0] b,
                                     input logic [16:0] s);
    pend_t p;
    k++;
    while (pq.size() > 0 && pq[0].due == k) begin
      p = pq.pop_front();
      apply(p.ed);
    end
    if (m_idle && st) begin
      m_cnt = 0; m_err = 0; m_max = 0; m_sum40 = 0; m_sum20 = 0;
      m_idle = 0;
      if (n == 0) begin
        m_done = 1;
      end else begin
        m_busy = 1; m_ready = 1; remaining = n;
      end
    end else if (m_done) begin
      m_done = 0; m_idle = 1;
    end else if (m_busy) begin
      if (m_ready && v) begin
        p.ed = ed_of(a, b, s); p.due = k + 2;
        pq.push_back(p);
        remaining--;
        if (remaining == 0) begin
          m_ready = 0;
          done_edge = k + 3;
        end
      end
      if (k == done_edge) begin
        m_busy = 0; m_done = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_all();
    chk("in_ready",   in_ready0,   64'(m_ready));
    chk("busy",       busy0,       64'(m_busy));
    chk("done",       done0,       64'(m_done));
    chk("sample_cnt", sample_cnt0, 64'(m_cnt));
    chk("err_count",  err_count0,  64'(m_err));
    chk("max_ed",     max_ed0,     64'(m_max));
    chk("sum_ed40",   sum_ed0,     m_sum40);
    chk("sum_ed20",   sum_ed1,     m_sum20);
    chk("err_count20", err_count1, 64'(m_err));
  endtask

  task automatic cyc(input bit st, input int unsigned n, input bit v,
                     input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    start = st; num_samples = n; in_valid = v; in_a = a; in_b = b; in_sum = s;
    @(posedge clk);
    model_edge(st, n, v, a, b, s);
    #1;
    check_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, '0, '0, '0);
  endtask

  task automatic rand_sample(output logic [15:0] a, output logic [15:0] b,
                             output logic [16:0] s);
    logic [16:0] ex;
    a  = 16'($urandom);
    b  = 16'($urandom);
    ex = {1'b0, a} + {1'b0, b};
    case ($urandom_range(2, 0))
      0:       s = ex;
      1:       s = ex ^ 17'($urandom_range(255, 1));
      default: s = 17'($urandom);
    endcase
  endtask

  task automatic feed(input int offers, input int pct_valid);
    logic [15:0] a, b;
    logic [16:0] s;
    for (int i = 0; i < offers; i++) begin
      rand_sample(a, b, s);
      cyc(0, 0, ($urandom_range(99, 0) < pct_valid), a, b, s);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int left;
    left = budget;
    while (!m_idle || m_done) begin
      if (left == 0) begin
        nvec++; nmis++;
        $error("FAIL timeout: window still open after %0d cycles, expected idle", budget);
        break;
      end
      idle_cyc();
      left--;
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    start = 0; in_valid = 0;
    #2;
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_busy",     busy0,     0);
    chk("rst_done",     done0,     0);
    chk("rst_cnt",      sample_cnt0, 0);
    chk("rst_err",      err_count0,  0);
    chk("rst_max",      max_ed0,     0);
    chk("rst_sum",      sum_ed0,     0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; start = 0; num_samples = 0; in_valid = 0;
    in_a = '0; in_b = '0; in_sum = '0;
    model_reset();
    @(posedge clk);
    do_reset();
    idle_cyc();

    // Reset mid-window, then a fresh one-sample window
    cyc(1, 10, 0, '0, '0, '0);
    feed(4, 100);
    idle_cyc();
    do_reset();
    idle_cyc();
    cyc(1, 1, 0, '0, '0, '0);
    feed(1, 100);
    run_until_idle(20);
    chk("after_rst_cnt", sample_cnt0, 1);

    // Exact samples
    cyc(1, 2, 0, '0, '0, '0);
    cyc(0, 0, 1, 16'h1234, 16'h0001, 17'h01235);
    cyc(0, 0, 1, 16'hFFFF, 16'h0001, 17'h10000);
    run_until_idle(20);
    chk("exact_cnt", sample_cnt0, 2);
    chk("exact_err", err_count0, 0);
    chk("exact_max", max_ed0, 0);
    chk("exact_sum", sum_ed0, 0);

    // Approximate errors, back to back
    cyc(1, 2, 0, '0, '0, '0);
    cyc(0, 0, 1, 16'h0FFF, 16'h0001, 17'h00FFF);
    cyc(0, 0, 1, 16'hFFFF, 16'hFFFF, 17'h00000);
    run_until_idle(20);
    chk("approx_err", err_count0, 2);
    chk("approx_max", max_ed0, 17'h1FFFE);
    chk("approx_sum", sum_ed0, 40'h1FFFF);

    // Window limit, toggling valid, start during RUN ignored
    cyc(1, 3, 0, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a, b;
      logic [16:0] s;
      rand_sample(a, b, s);
      cyc((i == 2), 7, (i % 2 == 1), a, b, s);
    end
    run_until_idle(20);
    chk("limit_cnt", sample_cnt0, 3);

    // Zero-length window
    cyc(1, 0, 1, 16'h0001, 16'h0001, 17'h0);
    chk("zero_done", done0, 1);
    run_until_idle(5);
    chk("zero_cnt", sample_cnt0, 0);

    // Saturation of the 20-bit accumulator
    cyc(1, 16, 0, '0, '0, '0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 16'hFFFF, 16'hFFFF, 17'h0);
    run_until_idle(20);
    chk("sat_sum20", sum_ed1, 20'hFFFFF);
    chk("sat_err",   err_count1, 16);
    chk("sat_max",   max_ed1, 17'h1FFFE);
    chk("sat_sum40", sum_ed0, 40'h1FFFE0);

    // Random windows
    for (int w = 0; w < 8; w++) begin
      cyc(1, $urandom_range(20, 1), 0, '0, '0, '0);
      while (m_busy && m_ready) feed(1, $urandom_range(100, 30));
      run_until_idle(20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/approx_adder_err_monitor.md
Name: approx_adder_err_monitor

Overview:
Measurement block that sits on the consumer side of the registered approximate adders (16-bit operands, 17-bit sum). It accepts operand pairs together with the approximate sum produced for them, recomputes the exact sum, and accumulates error statistics over a programmed window of samples. It reports error count, maximum error distance (ED) and cumulative ED for accuracy characterisation of each adder variant.

Parameters:
WIDTH, 16, operand width; sums and ED are WIDTH+1 bits
CNT_W, 32, width of the sample-count and error-count registers
ACC_W, 40, width of the cumulative-ED accumulator (saturating)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin a measurement window (honoured in IDLE only)
num_samples  input  CNT_W  window length; latched on accepted start
in_valid  input  1  sample present on in_a/in_b/in_sum
in_ready  output  1  monitor accepts a sample this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sum  input  WIDTH+1  approximate sum under test
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when statistics are final
sample_cnt  output  CNT_W  samples processed
err_count  output  CNT_W  samples with ED != 0
max_ed  output  WIDTH+1  largest ED observed
sum_ed  output  ACC_W  cumulative ED, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any state, including mid-window): FSM to IDLE; in_ready, busy, done, sample_cnt, err_count, max_ed, sum_ed all 0; pipeline valid bits cleared; in-flight samples discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. On start: clear all statistics, latch num_samples into target, clear accept counter. If num_samples==0, go to DONE; otherwise go to RUN. Statistics from the previous window stay visible until start.
- RUN: in_ready=1 while accept counter < target. Sample accepted on a cycle with in_valid && in_ready. When the accept that makes accept counter == target occurs, go to DRAIN; in_ready is 0 from the next cycle. Samples offered after that are not accepted.
- start in RUN, DRAIN or DONE: ignored.
- Pipeline: stage 1 registers in_a, in_b and in_sum on accept. Stage 2 computes exact = in_a + in_b (WIDTH+1 bits, unsigned, no truncation) and ED = |exact - in_sum| (WIDTH+1 bits, unsigned absolute difference), then updates statistics at the next edge.
- Latency: a sample accepted at edge t is reflected in the statistics after edge t+2.
- Statistics update for each valid stage-2 sample:
  - sample_cnt += 1.
  - err_count += 1 if ED != 0.
  - max_ed = max(max_ed, ED).
  - sum_ed += ED, saturating at 2^ACC_W - 1 and holding there.
- DRAIN: wait until both pipeline valid bits are 0, then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. At that point sample_cnt == target.
- busy: 1 in RUN and DRAIN, 0 otherwise.
- Gaps in in_valid during RUN are legal; nothing is counted on idle cycles.

Test Plan:
- Reset mid-window: start with num_samples=10, feed 4 samples, pulse rst_n low -> all outputs 0, FSM in IDLE. A fresh start with num_samples=1 completes normally.
- Exact samples: num_samples=2, samples (0x1234, 0x0001, 0x01235) and (0xFFFF, 0x0001, 0x10000) -> done pulse; sample_cnt=2, err_count=0, max_ed=0, sum_ed=0.
- Approximate error: samples (0x0FFF, 0x0001, 0x00FFF) and (0xFFFF, 0xFFFF, 0x00000) -> err_count=2, max_ed=0x1FFFE, sum_ed=0x1FFFF. Each statistic update appears 2 cycles after the accepting edge.
- Window limit and backpressure: num_samples=3, in_valid toggling, 5 samples offered -> exactly 3 accepted; in_ready low after the 3rd accept; sample_cnt=3; busy falls on the same cycle done rises; start pulsed during RUN has no effect.
- Zero-length window: start with num_samples=0 -> done pulses on the next cycle, in_ready never asserts, all statistics 0.
- Saturation: instance with ACC_W=20, num_samples=16, every sample ED=0x1FFFE -> sum_ed=0xFFFFF (held), err_count=16, max_ed=0x1FFFE.
